game_cmd_gen: RTL

Command generator feeding the game FSM's control inputs (startGame, pauseGame, dead, reset). It synchronises and debounces the raw board push-buttons and the collision flag, then maps each event to the command that is legal in the FSM's current state. It holds that command until the FSM's 3-bit state code reports the target state, or until a timeout expires. It sits between the board I/O and the game FSM, closing the loop on the FSM's dataout.

---
 rtl/game_cmd_gen.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/game_cmd_gen.sv
// Command generator for the game FSM: synchronises and debounces the board inputs, maps each
// event to the command legal in the FSM's current state, and holds it until acknowledged.
module game_cmd_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned ACK_TIMEOUT     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_n,
  input  logic       btn_pause_n,
  input  logic       btn_reset_n,
  input  logic       collision,
  input  logic [2:0] state_in,
  output logic       startGame,
  output logic       pauseGame,
  output logic       dead,
  output logic       game_reset,
  output logic       busy,
  output logic       err
);

  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DebMax  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [TmoW-1:0]  TmoOne  = TmoW'(1);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(ACK_TIMEOUT - 1);

  // Game FSM state codes
  localparam logic [2:0] FsmStart    = 3'b000;
  localparam logic [2:0] FsmPlaying  = 3'b001;
  localparam logic [2:0] FsmPause    = 3'b010;
  localparam logic [2:0] FsmReset    = 3'b011;
  localparam logic [2:0] FsmGameOver = 3'b100;

  // One-hot command encoding: {game_reset, dead, pauseGame, startGame}
  localparam logic [3:0] CmdStart = 4'b0001;
  localparam logic [3:0] CmdPause = 4'b0010;
  localparam logic [3:0] CmdDead  = 4'b0100;
  localparam logic [3:0] CmdReset = 4'b1000;

  typedef enum logic [1:0] {StIdle, StHold, StDone} state_e;

  // Button lanes: [0] start, [1] pause, [2] reset; all active-low, released = 1
  logic [2:0]            btn_raw;
  logic [2:0]            btn_s1_q, btn_s2_q;
  logic [2:0]            deb_q, deb_d, deb_prev_q;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  col_s1_q, col_s2_q, col_prev_q;

  logic [2:0] press;
  logic       col_ev;
  logic [3:0] req_cmd;
  logic [2:0] req_tgt;

  state_e          st_q, st_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [2:0]      tgt_q, tgt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  assign btn_raw = {btn_reset_n, btn_pause_n, btn_start_n};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q   <= '1;
      btn_s2_q   <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      cnt_q      <= '0;
      col_s1_q   <= 1'b0;
      col_s2_q   <= 1'b0;
      col_prev_q <= 1'b0;
    end else begin
      btn_s1_q   <= btn_raw;
      btn_s2_q   <= btn_s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      col_s1_q   <= collision;
      col_s2_q   <= col_s1_q;
      col_prev_q <= col_s2_q;
    end
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (btn_s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] + CntOne == DebMax) begin
          deb_d[i] = btn_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  // Press is taken from the registered debounced level so the command lands at DEBOUNCE_CYCLES+3
  assign press  = deb_prev_q & ~deb_q;
  assign col_ev = col_s2_q & ~col_prev_q;

  // Highest-priority event that is legal in the current game state wins
  always_comb begin
    req_cmd = '0;
    req_tgt = '0;
    if (press[2]) begin
      req_cmd = CmdReset;
      req_tgt = FsmReset;
    end else if (col_ev && state_in == FsmPlaying) begin
      req_cmd = CmdDead;
      req_tgt = FsmGameOver;
    end else if (press[1] && state_in == FsmPlaying) begin
      req_cmd = CmdPause;
      req_tgt = FsmPause;
    end else if (press[0]) begin
      case (state_in)
        FsmStart, FsmPause: begin
          req_cmd = CmdStart;
          req_tgt = FsmPlaying;
        end
        FsmReset, FsmGameOver: begin
          req_cmd = CmdStart;
          req_tgt = FsmStart;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_d   = st_q;
    cmd_d  = cmd_q;
    tgt_d  = tgt_q;
    tmo_d  = tmo_q;
    busy_d = busy_q;
    err_d  = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (|req_cmd) begin
          cmd_d  = req_cmd;
          tgt_d  = req_tgt;
          tmo_d  = '0;
          busy_d = 1'b1;
          st_d   = StHold;
        end
      end
      StHold: begin
        if (press[2]) begin
          cmd_d = CmdReset;
          tgt_d = FsmReset;
          tmo_d = '0;
        end else if (state_in == tgt_q) begin
          cmd_d  = '0;
          busy_d = 1'b0;
          st_d   = StDone;
        end else if (tmo_q == TmoLast) begin
          cmd_d  = '0;
          busy_d = 1'b0;
          err_d  = 1'b1;
          st_d   = StDone;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + TmoOne;
        end
      end
      StDone: begin
        cmd_d  = '0;
        busy_d = 1'b0;
        st_d   = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= StIdle;
      cmd_q  <= '0;
      tgt_q  <= '0;
      tmo_q  <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cmd_q  <= cmd_d;
      tgt_q  <= tgt_d;
      tmo_q  <= tmo_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign startGame  = cmd_q[0];
  assign pauseGame  = cmd_q[1];
  assign dead       = cmd_q[2];
  assign game_reset = cmd_q[3];
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
